// File: rtl/tuple_grant_arbiter.sv
// Two-requester round-robin arbiter with a bounded hold time.
// Grants are one-hot or all-zero and decode only from flops, so they never depend on the current inputs.
module tuple_grant_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req__0,
    input  logic             req__1,
    input  logic             release_req,
    output logic             gnt__0,
    output logic             gnt__1,
    output logic             busy,
    output logic             owner,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_owner, req_other, hold_end;

    // NOTE: sequential state uses non-blocking assignments only; blocking here would race with other flops.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        req_owner = owner_q ? req__1 : req__0;
        req_other = owner_q ? req__0 : req__1;
        hold_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req__0 | req__1) begin
                    state_d = OWN;
                    owner_d = (req__0 & req__1) ? ptr_q : req__1;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                hold_end = release_req | ~req_owner | ((cnt_q == HOLD_LAST) & req_other);
                if (hold_end) begin
                    // The finishing owner loses the next tie whether or not the other side takes over now.
                    ptr_d = ~owner_q;
                    cnt_d = '0;
                    if (req_other) begin
                        owner_d = ~owner_q;
                    end else begin
                        state_d = IDLE;
                        owner_d = 1'b0;
                    end
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == OWN);
        gnt__0   = busy & ~owner_q;
        gnt__1   = busy & owner_q;
        owner    = busy & owner_q;
        hold_cnt = cnt_q;
    end

endmodule

// File: tb/tb_tuple_grant_arbiter.sv
// Directed bench for tuple_grant_arbiter: a MAX_HOLD=4 instance checked throughout,
// plus a MAX_HOLD=1 instance checked for per-cycle alternation under contention.
module tb_tuple_grant_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       req__0, req__1, release_req;
    logic       gnt__0, gnt__1, busy, owner;
    logic [2:0] hold_cnt;
    logic       h1_gnt__0, h1_gnt__1, h1_busy, h1_owner;
    logic [0:0] h1_hold_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    tuple_grant_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .CLK(CLK), .RESET(RESET), .req__0(req__0), .req__1(req__1), .release_req(release_req),
        .gnt__0(gnt__0), .gnt__1(gnt__1), .busy(busy), .owner(owner), .hold_cnt(hold_cnt)
    );

    tuple_grant_arbiter #(.MAX_HOLD(1), .CNT_W(1)) dut_h1 (
        .CLK(CLK), .RESET(RESET), .req__0(req__0), .req__1(req__1), .release_req(release_req),
        .gnt__0(h1_gnt__0), .gnt__1(h1_gnt__1), .busy(h1_busy), .owner(h1_owner), .hold_cnt(h1_hold_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later; inputs set after this are taken at the following edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        check("one_hot", 32'(gnt__0 & gnt__1), 32'd0);
        check("busy_eq_or", 32'(busy), 32'(gnt__0 | gnt__1));
    endtask

    task automatic expect_out(input string tag, input logic g1, input logic g0, input logic b,
                              input logic o, input logic [2:0] c);
        check(tag, 32'({gnt__1, gnt__0, busy, owner, hold_cnt}), 32'({g1, g0, b, o, c}));
    endtask

    initial begin
        RESET = 1'b1; req__0 = 1'b1; req__1 = 1'b0; release_req = 1'b0;

        // Reset held two edges with a pending request
        tick(); expect_out("reset_e1", 0, 0, 0, 0, 3'd0);
        tick(); expect_out("reset_e2", 0, 0, 0, 0, 3'd0);
        RESET = 1'b0;
        tick(); expect_out("first_grant", 0, 1, 1, 0, 3'd0);

        // Owner 0 drops, nobody else waiting: idle, pointer now favours 1
        req__0 = 1'b0;
        tick(); expect_out("drop_to_idle", 0, 0, 0, 0, 3'd0);

        // Continuous tie: 4-cycle tenures with no gap; MAX_HOLD=1 instance alternates each cycle
        req__0 = 1'b1; req__1 = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            logic       o;
            logic [2:0] c;
            tick();
            o = ((k - 1) / 4) % 2 == 0;
            c = 3'((k - 1) % 4);
            expect_out($sformatf("tie_k%0d", k), o, ~o, 1, o, c);
            check($sformatf("h1_owner_k%0d", k), 32'({h1_busy, h1_owner, h1_hold_cnt}),
                  32'({1'b1, 1'(k % 2), 1'b0}));
        end

        // Owner 1 alone: counter saturates at 3 and the grant stays
        req__0 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            expect_out($sformatf("sat_k%0d", k), 1, 0, 1, 1, (k >= 3) ? 3'd3 : 3'(k));
        end

        // Owner 1 leaves while 0 waits: handover, then owner 0 reaches hold_cnt=1
        req__0 = 1'b1; req__1 = 1'b0;
        tick(); expect_out("handover_to0", 0, 1, 1, 0, 3'd0);
        tick(); expect_out("own0_cnt1", 0, 1, 1, 0, 3'd1);
        release_req = 1'b1; req__1 = 1'b1;
        tick(); expect_out("release_handover", 1, 0, 1, 1, 3'd0);

        // Back to owner 0 at hold_cnt=1, then release with nobody else waiting
        release_req = 1'b0; req__1 = 1'b0;
        tick(); expect_out("back_to0", 0, 1, 1, 0, 3'd0);
        tick(); expect_out("own0_cnt1_b", 0, 1, 1, 0, 3'd1);
        release_req = 1'b1;
        tick(); expect_out("release_idle", 0, 0, 0, 0, 3'd0);
        release_req = 1'b0; req__1 = 1'b1;
        tick(); expect_out("tie_after_release", 1, 0, 1, 1, 3'd0);

        // Owner 1 drops with no other request; release in IDLE changes nothing
        req__0 = 1'b0;
        tick(); expect_out("own1_cnt1", 1, 0, 1, 1, 3'd1);
        req__1 = 1'b0;
        tick(); expect_out("req_drop_idle", 0, 0, 0, 0, 3'd0);
        release_req = 1'b1;
        tick(); expect_out("release_in_idle", 0, 0, 0, 0, 3'd0);
        req__0 = 1'b1;
        tick(); expect_out("grant_despite_rel", 0, 1, 1, 0, 3'd0);

        // Build owner 1 at hold_cnt=2, then reset mid-tenure
        release_req = 1'b0; req__0 = 1'b0; req__1 = 1'b1;
        tick(); expect_out("to_own1", 1, 0, 1, 1, 3'd0);
        tick(); expect_out("own1_c1", 1, 0, 1, 1, 3'd1);
        tick(); expect_out("own1_c2", 1, 0, 1, 1, 3'd2);
        RESET = 1'b1;
        tick(); expect_out("mid_reset", 0, 0, 0, 0, 3'd0);
        RESET = 1'b0; req__0 = 1'b1;
        tick(); expect_out("tie_after_reset", 0, 1, 1, 0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tuple_grant_arbiter.md
Name: tuple_grant_arbiter

Overview:
- Two-requester round-robin arbiter with bounded hold time.
- Shares one resource, such as a two-field tuple output stage, between requesters 0 and 1.
- Drives a flattened two-element grant tuple (gnt__0, gnt__1) that is always one-hot or all-zero.
- Sits between the requesting sequential blocks and the shared combinational stage; all outputs are registered.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles an owner keeps the grant while the other requester waits; legal range is 1 or more.
CNT_W, 3, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD-1.

Ports:
CLK  input  1  rising-edge clock.
RESET  input  1  synchronous, active-high reset.
req__0  input  1  requester 0 wants the resource.
req__1  input  1  requester 1 wants the resource.
release  input  1  current owner finished; sampled only in OWN.
gnt__0  output  1  registered grant to requester 0.
gnt__1  output  1  registered grant to requester 1.
busy  output  1  high while a grant is held (state OWN).
owner  output  1  index of the current grantee; 0 when not busy.
hold_cnt  output  CNT_W  cycles the current owner has held the grant, minus 1; 0 when idle.

Behaviour:
- Single clock CLK. RESET is synchronous and active-high.
- Reset values, applied at the next edge with RESET high (including mid-operation):
  - state=IDLE
  - gnt__0=0, gnt__1=0, busy=0, owner=0, hold_cnt=0
  - priority pointer ptr=0 (requester 0 wins the first tie)
- Invariant: gnt__0 & gnt__1 is never 1.
- Invariant: busy == (gnt__0 | gnt__1).
- Grant latency: a request sampled at edge N yields a grant visible after edge N (one cycle).
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req: grant requester ptr.
  - On any grant: go to OWN, hold_cnt=0.
- OWN, evaluated each edge; "other" means the non-owner requester.
  - end = release | ~req_owner | (hold_cnt==MAX_HOLD-1 & req_other).
  - If end and req_other: hand over with no bubble. owner<=other, hold_cnt<=0, ptr<=~old owner.
  - If end and ~req_other: go to IDLE, grants low, ptr<=~old owner.
  - If not end: hold_cnt<=min(hold_cnt+1, MAX_HOLD-1), saturating with no wrap.
  - When hold_cnt saturates and no contention exists, the owner keeps the grant indefinitely.
- MAX_HOLD=1: under continuous contention the grant alternates every cycle.
- Release with the owner still requesting and the other idle: one IDLE cycle, then re-grant to the same owner.
- release is ignored in IDLE.
- Requests are level-sensitive; no request is latched or queued.
- RESET asserted in OWN: grant drops at that edge with no handover.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles with req__0=1; release RESET → gnt=00 during reset, gnt__0=1 one cycle after the first non-reset edge, owner=0, hold_cnt=0.
- Tie and rotation: from IDLE, req__0=req__1=1 held, MAX_HOLD=4 → gnt__0 for 4 cycles (hold_cnt 0,1,2,3), then gnt__1 for 4 cycles, alternating with no idle gap; gnt is never 11.
- Uncontended saturation: only req__1=1 for 10 cycles → gnt__1 stays 1 throughout, and hold_cnt reaches 3 and stays at 3.
- Release handover: owner 0 at hold_cnt=1 with release=1 and req__1=1 → next cycle gnt__1=1, hold_cnt=0; with req__1=0 instead → gnt=00, busy=0, and ptr favors requester 1 on the next tie.
- Request drop: owner 1 deasserts req__1 with no other request → gnt=00 next cycle; release pulsed in IDLE → no change.
- Mid-operation reset: RESET pulsed while gnt__1=1 and hold_cnt=2 → all outputs return to reset values at that edge, and the next tie grants requester 0.
